// File: rtl/operand_fetch_pkg.sv
// Shared operand-fetch definitions: widths, register count, ALU action and branch-type encodings.
// Also holds the writeback-match helper used by the bypass and hazard logic.
package operand_fetch_pkg;

  localparam int OF_WORD_SIZE = 16;
  localparam int OF_NUM_REGS  = 4;
  localparam int OF_REG_AW    = 2;
  localparam int OF_ACT_W     = 4;
  localparam int OF_BTYPE_W   = 3;

  typedef logic [OF_REG_AW-1:0] reg_addr_t;

  typedef enum logic [OF_ACT_W-1:0] {
    ALU_ADD    = 4'h0,
    ALU_SUB    = 4'h1,
    ALU_AND    = 4'h2,
    ALU_OR     = 4'h3,
    ALU_XOR    = 4'h4,
    ALU_SLL    = 4'h5,
    ALU_SRL    = 4'h6,
    ALU_SRA    = 4'h7,
    ALU_SLT    = 4'h8,
    ALU_SLTU   = 4'h9,
    ALU_PASS_B = 4'hA
  } alu_action_e;

  typedef enum logic [OF_BTYPE_W-1:0] {
    BT_NONE = 3'h0,
    BT_EQ   = 3'h1,
    BT_NE   = 3'h2,
    BT_LT   = 3'h3,
    BT_GE   = 3'h4,
    BT_LTU  = 3'h5,
    BT_GEU  = 3'h6,
    BT_JMP  = 3'h7
  } btype_e;

  function automatic logic wb_hits(logic wb_valid, reg_addr_t wb_addr, reg_addr_t idx);
    return wb_valid && (wb_addr == idx);
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode-side, ALU-side and writeback signals of the operand fetch stage.
// master drives instructions/writebacks and consumes operands; slave is the stage itself.
interface operand_fetch_if
  import operand_fetch_pkg::*;
#(
  parameter int WORD_SIZE = OF_WORD_SIZE
);

  logic                  in_valid;
  logic                  in_ready;
  reg_addr_t             rs1_addr;
  reg_addr_t             rs2_addr;
  logic                  use_rs2;
  logic [WORD_SIZE-1:0]  imm;
  reg_addr_t             rd_addr;
  logic                  rd_we;
  logic [OF_ACT_W-1:0]   alu_action;
  logic [OF_BTYPE_W-1:0] btype;

  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_SIZE-1:0]  out_A;
  logic [WORD_SIZE-1:0]  out_B;
  logic [OF_ACT_W-1:0]   out_action;
  logic [OF_BTYPE_W-1:0] out_btype;
  reg_addr_t             out_rd;
  logic                  out_rd_we;

  logic                  wb_valid;
  reg_addr_t             wb_addr;
  logic [WORD_SIZE-1:0]  wb_data;

  modport master (
    output in_valid, rs1_addr, rs2_addr, use_rs2, imm, rd_addr, rd_we, alu_action, btype,
    output out_ready, wb_valid, wb_addr, wb_data,
    input  in_ready, out_valid, out_A, out_B, out_action, out_btype, out_rd, out_rd_we
  );

  modport slave (
    input  in_valid, rs1_addr, rs2_addr, use_rs2, imm, rd_addr, rd_we, alu_action, btype,
    input  out_ready, wb_valid, wb_addr, wb_data,
    output in_ready, out_valid, out_A, out_B, out_action, out_btype, out_rd, out_rd_we
  );

endinterface

// File: rtl/operand_fetch_regfile.sv
// 2-read/1-write register file; reads are combinational with write-through bypass.
// Writes land on the clock edge; reset clears all entries and suppresses the bypass.
module regfile
  import operand_fetch_pkg::*;
#(
  parameter int WORD_SIZE = OF_WORD_SIZE,
  parameter int NUM_REGS  = OF_NUM_REGS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  reg_addr_t            ra1,
  input  reg_addr_t            ra2,
  output logic [WORD_SIZE-1:0] rd1,
  output logic [WORD_SIZE-1:0] rd2,
  input  logic                 we,
  input  reg_addr_t            wa,
  input  logic [WORD_SIZE-1:0] wd
);

  logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
  logic [WORD_SIZE-1:0] regs_d [NUM_REGS];
  logic                 we_eff;

  // A writeback coincident with reset must neither land nor bypass.
  assign we_eff = we && !reset;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (we_eff) begin
      regs_d[wa] = wd;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reset) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign rd1 = wb_hits(we_eff, wa, ra1) ? wd : regs_q[ra1];
  assign rd2 = wb_hits(we_eff, wa, ra2) ? wd : regs_q[ra2];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: regfile read, RAW scoreboard, registered ALU operands; 1-cycle latency.
// in_ready drops on a pending source (unless written back this cycle) or while the output is held.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int WORD_SIZE = OF_WORD_SIZE,
  parameter int NUM_REGS  = OF_NUM_REGS
) (
  input logic           clk,
  input logic           reset,
  operand_fetch_if.slave io
);

  logic [WORD_SIZE-1:0]  rs1_val;
  logic [WORD_SIZE-1:0]  rs2_val;
  logic                  hazard;
  logic                  in_ready;
  logic                  accept;

  logic [NUM_REGS-1:0]   pend_q, pend_d;
  logic                  out_valid_q, out_valid_d;
  logic [WORD_SIZE-1:0]  out_a_q, out_a_d;
  logic [WORD_SIZE-1:0]  out_b_q, out_b_d;
  logic [OF_ACT_W-1:0]   out_act_q, out_act_d;
  logic [OF_BTYPE_W-1:0] out_bt_q, out_bt_d;
  reg_addr_t             out_rd_q, out_rd_d;
  logic                  out_we_q, out_we_d;

  regfile #(
    .WORD_SIZE (WORD_SIZE),
    .NUM_REGS  (NUM_REGS)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .ra1   (io.rs1_addr),
    .ra2   (io.rs2_addr),
    .rd1   (rs1_val),
    .rd2   (rs2_val),
    .we    (io.wb_valid),
    .wa    (io.wb_addr),
    .wd    (io.wb_data)
  );

  // A source being written back this cycle is satisfied by the regfile bypass.
  always_comb begin
    hazard = (pend_q[io.rs1_addr] && !wb_hits(io.wb_valid, io.wb_addr, io.rs1_addr)) ||
             (io.use_rs2 && pend_q[io.rs2_addr] &&
              !wb_hits(io.wb_valid, io.wb_addr, io.rs2_addr));
  end

  assign in_ready    = !reset && !hazard && (!out_valid_q || io.out_ready);
  assign accept      = io.in_valid && in_ready;
  assign io.in_ready = in_ready;

  // Clear first so a same-cycle set of the same bit wins.
  always_comb begin
    pend_d = pend_q;
    if (io.wb_valid) begin
      pend_d[io.wb_addr] = 1'b0;
    end
    if (accept && io.rd_we) begin
      pend_d[io.rd_addr] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_act_d   = out_act_q;
    out_bt_d    = out_bt_q;
    out_rd_d    = out_rd_q;
    out_we_d    = out_we_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_a_d     = rs1_val;
      out_b_d     = io.use_rs2 ? rs2_val : io.imm;
      out_act_d   = io.alu_action;
      out_bt_d    = io.btype;
      out_rd_d    = io.rd_addr;
      out_we_d    = io.rd_we;
    end else if (io.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_act_q   <= '0;
      out_bt_q    <= '0;
      out_rd_q    <= '0;
      out_we_q    <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_act_q   <= out_act_d;
      out_bt_q    <= out_bt_d;
      out_rd_q    <= out_rd_d;
      out_we_q    <= out_we_d;
    end
  end

  assign io.out_valid  = out_valid_q;
  assign io.out_A      = out_a_q;
  assign io.out_B      = out_b_q;
  assign io.out_action = out_act_q;
  assign io.out_btype  = out_bt_q;
  assign io.out_rd     = out_rd_q;
  assign io.out_rd_we  = out_we_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: vector table with expected in_ready, plus a reference register
// model and an expected-output queue checked on every cycle the output is valid.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  operand_fetch_if ifc ();

  operand_fetch dut (
    .clk   (clk),
    .reset (reset),
    .io    (ifc)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [1:0]  rs1;
    logic [1:0]  rs2;
    logic        u2;
    logic [15:0] imm;
    logic [1:0]  rd;
    logic        we;
    logic [3:0]  act;
    logic [2:0]  bt;
    logic        ordy;
    logic        wbv;
    logic [1:0]  wba;
    logic [15:0] wbd;
    logic        exp_rdy;
  } vec_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  act;
    logic [2:0]  bt;
    logic [1:0]  rd;
    logic        we;
  } out_t;

  out_t        exp_q[$];
  logic [15:0] rf[4];
  logic        model_ov;
  int          checks   = 0;
  int          failures = 0;
  vec_t        tbl[$];

  function automatic vec_t mk(logic rst, logic iv, logic [1:0] rs1, logic [1:0] rs2, logic u2,
                              logic [15:0] imm, logic [1:0] rd, logic we, logic [3:0] act,
                              logic [2:0] bt, logic ordy, logic wbv, logic [1:0] wba,
                              logic [15:0] wbd, logic exp_rdy);
    vec_t v;
    v.rst = rst; v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.u2 = u2; v.imm = imm;
    v.rd = rd; v.we = we; v.act = act; v.bt = bt; v.ordy = ordy;
    v.wbv = wbv; v.wba = wba; v.wbd = wbd; v.exp_rdy = exp_rdy;
    return v;
  endfunction

  function automatic logic [15:0] read_model(vec_t v, logic [1:0] a);
    return (v.wbv && !v.rst && v.wba == a) ? v.wbd : rf[a];
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic apply(vec_t v);
    reset          = v.rst;
    ifc.in_valid   = v.iv;
    ifc.rs1_addr   = v.rs1;
    ifc.rs2_addr   = v.rs2;
    ifc.use_rs2    = v.u2;
    ifc.imm        = v.imm;
    ifc.rd_addr    = v.rd;
    ifc.rd_we      = v.we;
    ifc.alu_action = v.act;
    ifc.btype      = v.bt;
    ifc.out_ready  = v.ordy;
    ifc.wb_valid   = v.wbv;
    ifc.wb_addr    = v.wba;
    ifc.wb_data    = v.wbd;
  endtask

  task automatic step(vec_t v, string tag);
    out_t got;
    out_t e;
    apply(v);
    @(negedge clk);
    chk($sformatf("%s in_ready", tag), 64'(ifc.in_ready), 64'(v.exp_rdy));
    chk($sformatf("%s out_valid", tag), 64'(ifc.out_valid), 64'(model_ov));
    if (model_ov) begin
      got = {ifc.out_A, ifc.out_B, ifc.out_action, ifc.out_btype, ifc.out_rd, ifc.out_rd_we};
      chk($sformatf("%s out_fields", tag), 64'(got), 64'(exp_q[0]));
      if (v.ordy) void'(exp_q.pop_front());
    end
    if (v.iv && v.exp_rdy) begin
      e.a   = read_model(v, v.rs1);
      e.b   = v.u2 ? read_model(v, v.rs2) : v.imm;
      e.act = v.act;
      e.bt  = v.bt;
      e.rd  = v.rd;
      e.we  = v.we;
      exp_q.push_back(e);
      model_ov = 1'b1;
    end else if (v.ordy) begin
      model_ov = 1'b0;
    end
    if (v.rst) begin
      model_ov = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 4; i++) rf[i] = 16'h0;
    end else if (v.wbv) begin
      rf[v.wba] = v.wbd;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outputs(string tag);
    chk($sformatf("%s out_valid", tag), 64'(ifc.out_valid), 64'h0);
    chk($sformatf("%s out_regs", tag),
        64'({ifc.out_A, ifc.out_B, ifc.out_action, ifc.out_btype, ifc.out_rd, ifc.out_rd_we}),
        64'h0);
  endtask

  initial begin
    vec_t rst_v;
    model_ov = 1'b0;
    for (int i = 0; i < 4; i++) rf[i] = 16'h0;

    // Initial reset: first edge clears state, second reset cycle is checked.
    rst_v = mk(1, 0, 0, 0, 0, 16'h0, 0, 0, 4'h0, 3'h0, 1, 0, 0, 16'h0, 0);
    apply(rst_v);
    @(posedge clk);
    #1;
    step(rst_v, "reset");
    chk_zero_outputs("reset_state");

    //           rst iv rs1 rs2 u2 imm       rd we act    bt    ordy wbv wba wbd       rdy
    tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 4'h0, 3'h0, 1, 1, 1, 16'h1234, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0005, 0, 0, 4'h3, 3'h1, 1, 0, 0, 16'h0000, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 4'h0, 3'h0, 1, 0, 0, 16'h0000, 1));
    // RAW on r2 stalls until its writeback, which is bypassed in the same cycle
    tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0011, 2, 1, 4'h1, 3'h2, 1, 0, 0, 16'h0000, 1));
    tbl.push_back(mk(0, 1, 2, 0, 0, 16'h0000, 0, 0, 4'h2, 3'h0, 1, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 2, 0, 0, 16'h0000, 0, 0, 4'h2, 3'h0, 1, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 2, 0, 0, 16'h0000, 0, 0, 4'h2, 3'h0, 1, 1, 2, 16'hBEEF, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 4'h0, 3'h0, 1, 0, 0, 16'h0000, 1));
    // Output held three cycles; writeback to captured r1 while held
    tbl.push_back(mk(0, 1, 1, 2, 1, 16'h0000, 1, 0, 4'h5, 3'h3, 1, 0, 0, 16'h0000, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0077, 0, 0, 4'h6, 3'h4, 0, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0077, 0, 0, 4'h6, 3'h4, 0, 1, 1, 16'h5555, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0077, 0, 0, 4'h6, 3'h4, 0, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0077, 0, 0, 4'h6, 3'h4, 1, 0, 0, 16'h0000, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 4'h0, 3'h0, 1, 0, 0, 16'h0000, 1));
    // Set of pending[3] beats a coincident writeback to r3
    tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0015, 3, 1, 4'h7, 3'h5, 1, 1, 3, 16'h0333, 1));
    tbl.push_back(mk(0, 1, 3, 0, 0, 16'h0016, 0, 0, 4'h8, 3'h6, 1, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 3, 0, 0, 16'h0016, 0, 0, 4'h8, 3'h6, 1, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 3, 0, 0, 16'h0016, 0, 0, 4'h8, 3'h6, 1, 1, 3, 16'h3333, 1));
    // Four independent back-to-back issues
    tbl.push_back(mk(0, 1, 1, 3, 1, 16'h0000, 2, 0, 4'h9, 3'h7, 1, 0, 0, 16'h0000, 1));
    tbl.push_back(mk(0, 1, 2, 0, 0, 16'h1020, 1, 0, 4'hA, 3'h0, 1, 0, 0, 16'h0000, 1));
    tbl.push_back(mk(0, 1, 3, 1, 1, 16'h0000, 3, 0, 4'hB, 3'h1, 1, 0, 0, 16'h0000, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 16'hFFFF, 0, 1, 4'hC, 3'h2, 1, 0, 0, 16'h0000, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 4'h0, 3'h0, 0, 0, 0, 16'h0000, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset while output held and pending[0] set; coincident writeback to r0 is dropped.
    step(mk(1, 1, 0, 0, 0, 16'h0000, 0, 0, 4'h0, 3'h0, 0, 1, 0, 16'hAAAA, 0), "midreset");
    chk_zero_outputs("midreset_state");
    step(mk(0, 1, 0, 0, 1, 16'h0000, 1, 1, 4'hD, 3'h3, 1, 0, 0, 16'h0000, 1), "post_reset_r0");
    step(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 4'h0, 3'h0, 1, 0, 0, 16'h0000, 1), "post_reset_out");
    step(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 4'h0, 3'h0, 1, 0, 0, 16'h0000, 1), "idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter WORD_SIZE, default 16: datapath width, shared with the ALU.
REQ-002 Parameter NUM_REGS, default 4: architectural registers, addressed by 2 bits.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  decoded instruction present.
REQ-006 in_ready  out  1  instruction accepted this cycle when in_valid && in_ready.
REQ-007 rs1_addr, rs2_addr  in  2 each  source register indices.
REQ-008 use_rs2  in  1  B operand from register rs2 (1) or from imm (0).
REQ-009 imm  in  WORD_SIZE  sign/zero-extended immediate, already formed by the decoder.
REQ-010 rd_addr  in  2, rd_we  in  1  destination index and write intent.
REQ-011 alu_action  in  4, btype  in  3  passed through to the ALU stage.
REQ-012 out_valid  out  1, out_ready  in  1  downstream handshake; transfer when both high.
REQ-013 out_A, out_B  out  WORD_SIZE  ALU operands.
REQ-014 out_action  out  4, out_btype  out  3, out_rd  out  2, out_rd_we  out  1  registered pass-through.
REQ-015 wb_valid  in  1, wb_addr  in  2, wb_data  in  WORD_SIZE  writeback port.

Function
REQ-016 Register file of NUM_REGS x WORD_SIZE with two combinational read ports and one write port, written at the clock edge when wb_valid.
REQ-017 Write-through bypass: a read of wb_addr in the cycle where wb_valid is high returns wb_data.
REQ-018 Scoreboard of NUM_REGS pending bits; bit rd_addr is set on acceptance of an instruction with rd_we=1; bit wb_addr is cleared when wb_valid.
REQ-019 Same-cycle set and clear of the same bit: set wins.
REQ-020 Hazard = (pending[rs1_addr] && !(wb_valid && wb_addr==rs1_addr)) || (use_rs2 && pending[rs2_addr] && !(wb_valid && wb_addr==rs2_addr)).
REQ-021 in_ready = !hazard && (!out_valid || out_ready); in_ready is independent of in_valid.
REQ-022 On acceptance, the output register loads in the next edge: out_A = rs1 value, out_B = use_rs2 ? rs2 value : imm, with the remaining fields passed through unchanged.
REQ-023 Latency: accepted instruction appears on the outputs exactly 1 cycle later; throughput 1 per cycle with no hazard and out_ready held high.
REQ-024 out_valid is set on acceptance; it is cleared when out_ready && !accept; it stays high while out_ready is low.
REQ-025 All out_* fields are held stable while out_valid && !out_ready.
REQ-026 Writeback to a register already captured in the output register does not alter out_A/out_B.
REQ-027 Writeback while stalled is accepted every cycle and is never back-pressured.

Reset
REQ-028 In the reset cycle: all registers 0, pending bits 0, out_valid 0, and out_A/out_B/out_action/out_btype/out_rd/out_rd_we 0.
REQ-029 Reset mid-operation discards the held output and clears the scoreboard; a wb_valid coincident with reset is ignored.
REQ-030 in_ready is 0 during the reset cycle.

Structure
REQ-031 WORD_SIZE, register-address width and NUM_REGS are defined in the shared macro/package header, alongside the ALUAction and btype encodings.
REQ-032 The register file is one sub-module, regfile (2R1W, with bypass); scoreboard and output register remain in operand_fetch.

Verification
REQ-033 Reset, then wb r1=0x1234, issue rs1=1, use_rs2=0, imm=0x0005 -> next cycle out_valid=1, out_A=0x1234, out_B=0x0005.
REQ-034 Issue rd=2 with rd_we=1, then next issue rs1=2 -> in_ready=0 until wb_valid to r2=0xBEEF, then accepted in that cycle with out_A=0xBEEF.
REQ-035 out_ready=0 for 3 cycles with out_valid=1 -> outputs constant, in_ready=0; out_ready=1 -> the next instruction is accepted the same cycle.
REQ-036 Same cycle: accept with rd=3, rd_we=1, and wb_valid to r3 -> pending[3]=1 afterwards, so a following read of r3 stalls.
REQ-037 Back-to-back 4 independent issues with out_ready=1 -> 4 outputs on consecutive cycles, in order.
REQ-038 Assert reset while out_valid=1 and pending[0]=1 -> next cycle out_valid=0, all pending bits 0, and r0 read returns 0x0000.
